// File: rtl/window_gen.sv
// window_gen: 3x3 sliding-window generator for a raster pixel stream.
//   Pixels arrive row-major from (0,0). Two line buffers hold the previous
//   two rows. A 3x3 register array shifts left by one column on every
//   accepted pixel. A window is emitted only when it lies entirely inside
//   the current frame (row >= 2 and col >= 2).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               synchronous restart of frame position, drops pending window
//   in_valid/in_ready   input pixel handshake, in_pix is the pixel data
//   out_valid/out_ready output window handshake
//   w0..w8              window, row-major (w0 top-left, w8 bottom-right)
//   out_first/out_last  first / last window of the frame
module window_gen #(
  parameter int DW = 8,
  parameter int W  = 64,
  parameter int H  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pix,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] w0,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w3,
  output logic [DW-1:0] w4,
  output logic [DW-1:0] w5,
  output logic [DW-1:0] w6,
  output logic [DW-1:0] w7,
  output logic [DW-1:0] w8,
  output logic          out_first,
  output logic          out_last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ov_q, ov_d;
  logic          of_q, of_d;
  logic          ol_q, ol_d;
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];

  // lb1 holds row-1, lb2 holds row-2, both indexed by column.
  logic [DW-1:0] lb1_q [W];
  logic [DW-1:0] lb2_q [W];

  logic          accept;
  logic          emit;
  logic          col_end;
  logic          row_end;
  logic [DW-1:0] tap1;
  logic [DW-1:0] tap2;

  // A stalled window blocks intake, so the window registers never shift
  // while a window is waiting to be taken.
  assign in_ready = !clear && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_end  = (col_q == CW'(W - 1));
  assign row_end  = (row_q == RW'(H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign tap1     = lb1_q[col_q];
  assign tap2     = lb2_q[col_q];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ov_d  = ov_q;
    of_d  = of_q;
    ol_d  = ol_q;
    for (int unsigned i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end

    if (clear) begin
      col_d = '0;
      row_d = '0;
      ov_d  = 1'b0;
    end else begin
      if (ov_q && out_ready) begin
        ov_d = 1'b0;
      end
      if (accept) begin
        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end

        // shift left; new right column is {row-2, row-1, current} at col
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = tap2;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = tap1;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = in_pix;

        if (emit) begin
          ov_d = 1'b1;
          of_d = (row_q == RW'(2)) && (col_q == CW'(2));
          ol_d = row_end && col_end;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ov_q  <= 1'b0;
      of_q  <= 1'b0;
      ol_q  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ov_q  <= ov_d;
      of_q  <= of_d;
      ol_q  <= ol_d;
      for (int unsigned i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line buffers are not reset; every entry read for an emitted window was
  // written earlier in the same frame.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      lb2_q[col_q] <= tap1;
      lb1_q[col_q] <= in_pix;
    end
  end

  assign out_valid = ov_q;
  assign out_first = of_q;
  assign out_last  = ol_q;
  assign w0 = win_q[0];
  assign w1 = win_q[1];
  assign w2 = win_q[2];
  assign w3 = win_q[3];
  assign w4 = win_q[4];
  assign w5 = win_q[5];
  assign w6 = win_q[6];
  assign w7 = win_q[7];
  assign w8 = win_q[8];

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;

  typedef struct packed {
    logic [8:0][7:0] w;
    logic            f;
    logic            l;
  } win_t;

  typedef struct packed {
    logic [1:0] tl_r;
    logic [1:0] tl_c;
    win_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear;

  // 4x4 instance
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_first, a_last;
  logic [7:0] a_in_pix, a_w0, a_w1, a_w2, a_w3, a_w4, a_w5, a_w6, a_w7, a_w8;
  win_t       a_act;

  // 64x64 instance
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_first, b_last;
  logic [7:0] b_in_pix, b_w0, b_w1, b_w2, b_w3, b_w4, b_w5, b_w6, b_w7, b_w8;
  win_t       b_act;

  window_gen #(.DW(8), .W(4), .H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pix(a_in_pix),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .w0(a_w0), .w1(a_w1), .w2(a_w2), .w3(a_w3), .w4(a_w4),
    .w5(a_w5), .w6(a_w6), .w7(a_w7), .w8(a_w8),
    .out_first(a_first), .out_last(a_last)
  );

  window_gen #(.DW(8), .W(64), .H(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pix(b_in_pix),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .w0(b_w0), .w1(b_w1), .w2(b_w2), .w3(b_w3), .w4(b_w4),
    .w5(b_w5), .w6(b_w6), .w7(b_w7), .w8(b_w8),
    .out_first(b_first), .out_last(b_last)
  );

  always_comb begin
    a_act.w[0] = a_w0; a_act.w[1] = a_w1; a_act.w[2] = a_w2;
    a_act.w[3] = a_w3; a_act.w[4] = a_w4; a_act.w[5] = a_w5;
    a_act.w[6] = a_w6; a_act.w[7] = a_w7; a_act.w[8] = a_w8;
    a_act.f = a_first; a_act.l = a_last;
    b_act.w[0] = b_w0; b_act.w[1] = b_w1; b_act.w[2] = b_w2;
    b_act.w[3] = b_w3; b_act.w[4] = b_w4; b_act.w[5] = b_w5;
    b_act.w[6] = b_w6; b_act.w[7] = b_w7; b_act.w[8] = b_w8;
    b_act.f = b_first; b_act.l = b_last;
  end

  int         total = 0;
  int         bad   = 0;
  int         ndeliv;
  logic [7:0] pq[$];
  win_t       exp_q[$];
  vec_t       tbl[4];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic win_t mkw(input int v0, input int v1, input int v2,
                               input int v3, input int v4, input int v5,
                               input int v6, input int v7, input int v8,
                               input bit f, input bit l);
    win_t x;
    x.w[0] = 8'(v0); x.w[1] = 8'(v1); x.w[2] = 8'(v2);
    x.w[3] = 8'(v3); x.w[4] = 8'(v4); x.w[5] = 8'(v5);
    x.w[6] = 8'(v6); x.w[7] = 8'(v7); x.w[8] = 8'(v8);
    x.f = f; x.l = l;
    return x;
  endfunction

  function automatic win_t add_base(input win_t x, input int b);
    win_t y = x;
    for (int i = 0; i < 9; i++) y.w[i] = x.w[i] + 8'(b);
    return y;
  endfunction

  function automatic logic [7:0] p64(input int r, input int c);
    return 8'(r * 5 + c * 3 + (r ^ c));
  endfunction

  task automatic load_frame4(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pq.push_back(8'(base + 4 * r + c));
  endtask

  task automatic load_exp4(input int base);
    for (int i = 0; i < 4; i++) exp_q.push_back(add_base(tbl[i].exp, base));
  endtask

  task automatic drive(input bit big, input bit rnd);
    logic       v;
    logic [7:0] p;
    v = (pq.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
    p = (pq.size() > 0) ? pq[0] : 8'h00;
    if (big) begin b_in_valid = v; b_in_pix = p; end
    else     begin a_in_valid = v; a_in_pix = p; end
  endtask

  // One clock: observe handshakes at the falling edge, update stimulus after the rising edge.
  task automatic step(input bit big, input bit rnd);
    bit   fi, fo;
    win_t act;
    @(negedge clk);
    if (big) begin
      fi = b_in_valid && b_in_ready; fo = b_out_valid && b_out_ready; act = b_act;
    end else begin
      fi = a_in_valid && a_in_ready; fo = a_out_valid && a_out_ready; act = a_act;
    end
    if (fo) begin
      ndeliv++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_window got=%h expected=none", act);
      end else begin
        chk("window", 80'(act), 80'(exp_q.pop_front()));
      end
    end
    @(posedge clk); #1;
    if (fi && pq.size() > 0) void'(pq.pop_front());
    if (rnd) begin
      if (big) b_out_ready = ($urandom_range(0, 3) != 0);
      else     a_out_ready = ($urandom_range(0, 3) != 0);
    end
    drive(big, rnd);
  endtask

  task automatic run_done(input bit big, input bit rnd, input int budget, input string nm);
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      step(big, rnd);
      n++;
      done = (pq.size() == 0) && (exp_q.size() == 0) && !(big ? b_out_valid : a_out_valid);
    end
    chk(nm, 80'(done), 80'(1));
  endtask

  initial begin
    int n;
    tbl[0] = '{2'd0, 2'd0, mkw(0, 1, 2, 4, 5, 6, 8, 9, 10, 1'b1, 1'b0)};
    tbl[1] = '{2'd0, 2'd1, mkw(1, 2, 3, 5, 6, 7, 9, 10, 11, 1'b0, 1'b0)};
    tbl[2] = '{2'd1, 2'd0, mkw(4, 5, 6, 8, 9, 10, 12, 13, 14, 1'b0, 1'b0)};
    tbl[3] = '{2'd1, 2'd1, mkw(5, 6, 7, 9, 10, 11, 13, 14, 15, 1'b0, 1'b1)};

    rst_n = 1'b0; clear = 1'b0;
    a_in_valid = 1'b0; a_in_pix = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_pix = '0; b_out_ready = 1'b1;
    ndeliv = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 80'(a_out_valid), 80'(0));
    chk("reset_window", 80'(a_act), 80'(0));
    chk("reset_in_ready", 80'(a_in_ready), 80'(1));
    chk("reset_b_out_valid", 80'(b_out_valid), 80'(0));
    rst_n = 1'b1;

    // basic 4x4 frame from the vector table
    load_frame4(0); load_exp4(0); ndeliv = 0;
    drive(0, 0);
    run_done(0, 0, 200, "frame_done");
    chk("frame_count", 80'(ndeliv), 80'(4));

    // backpressure on the first window
    load_frame4(0); load_exp4(0); ndeliv = 0;
    a_out_ready = 1'b0;
    drive(0, 0);
    n = 0;
    while (!a_out_valid && n < 50) begin step(0, 0); n++; end
    chk("stall_reached", 80'(a_out_valid), 80'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 80'(a_out_valid), 80'(1));
      chk("stall_in_ready", 80'(a_in_ready), 80'(0));
      chk("stall_window", 80'(a_act), 80'(tbl[0].exp));
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    run_done(0, 0, 200, "stall_done");
    chk("stall_count", 80'(ndeliv), 80'(4));

    // two back-to-back frames
    load_frame4(0); load_frame4(100); load_exp4(0); load_exp4(100); ndeliv = 0;
    drive(0, 0);
    run_done(0, 0, 300, "b2b_done");
    chk("b2b_count", 80'(ndeliv), 80'(8));

    // clear after 9 accepted pixels, with in_valid high
    load_frame4(0); ndeliv = 0;
    drive(0, 0);
    n = 0;
    while (pq.size() > 7 && n < 100) begin step(0, 0); n++; end
    chk("clear_prefix", 80'(pq.size()), 80'(7));
    clear = 1'b1;
    @(negedge clk);
    chk("clear_in_valid", 80'(a_in_valid), 80'(1));
    chk("clear_in_ready", 80'(a_in_ready), 80'(0));
    @(posedge clk); #1;
    clear = 1'b0;
    pq.delete();
    load_frame4(0); load_exp4(0);
    drive(0, 0);
    run_done(0, 0, 200, "clear_done");
    chk("clear_count", 80'(ndeliv), 80'(4));

    // reset mid-frame while a window is pending
    load_frame4(0); ndeliv = 0;
    a_out_ready = 1'b0;
    drive(0, 0);
    n = 0;
    while (!a_out_valid && n < 50) begin step(0, 0); n++; end
    chk("rst_pending", 80'(a_out_valid), 80'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 80'(a_out_valid), 80'(0));
    chk("rst_window", 80'(a_act), 80'(0));
    pq.delete();
    a_out_ready = 1'b1;
    load_frame4(0); load_exp4(0);
    drive(0, 0);
    run_done(0, 0, 200, "rst_done");
    chk("rst_count", 80'(ndeliv), 80'(4));

    // 64x64 frame with random gaps on both sides
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        pq.push_back(p64(r, c));
    for (int tr = 0; tr < 62; tr++)
      for (int tc = 0; tc < 62; tc++) begin
        win_t e;
        for (int k = 0; k < 9; k++) e.w[k] = p64(tr + k / 3, tc + k % 3);
        e.f = (tr == 0 && tc == 0);
        e.l = (tr == 61 && tc == 61);
        exp_q.push_back(e);
      end
    ndeliv = 0;
    drive(1, 1);
    run_done(1, 1, 40000, "big_done");
    chk("big_count", 80'(ndeliv), 80'(3844));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
